// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and the digit-validity helper used by the
// BCD up/down counter and its per-digit cell.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the BCD counter: clear, load (invalid digits become 0)
// and a single up/down step with 9<->0 rollover.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t d,
  output bcd_digit_t q,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t q_next;

  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = BCD_MIN;
    end else if (load) begin
      q_next = bcd_valid(d) ? d : BCD_MIN;
    end else if (step) begin
      if (up) begin
        q_next = (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      end else begin
        q_next = (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= BCD_MIN;
    end else begin
      q <= q_next;
    end
  end

  assign at_max = (q == BCD_MAX);
  assign at_min = (q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with ripple-enable carry chain, terminal count
// and wrap pulse. Define BCD_CNT_LOAD_EN to add the load/load_val ports and load_err.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                up,
`ifdef BCD_CNT_LOAD_EN
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
`endif
  output logic [4*DIGITS-1:0] q,
  output logic                tc,
  output logic                wrap,
  output logic                load_err
);

  logic                load_s;
  logic [4*DIGITS-1:0] load_val_s;

`ifdef BCD_CNT_LOAD_EN
  assign load_s     = load;
  assign load_val_s = load_val;
`else
  assign load_s     = 1'b0;
  assign load_val_s = '0;
`endif

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] bad_digit;
  // chain_*[i]: every digit below i sits at its rollover value
  logic [DIGITS:0]   chain_up;
  logic [DIGITS:0]   chain_dn;

  assign chain_up[0] = 1'b1;
  assign chain_dn[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_t digit_q;

    assign chain_up[i+1] = chain_up[i] & at_max[i];
    assign chain_dn[i+1] = chain_dn[i] & at_min[i];
    assign step[i]       = en & (up ? chain_up[i] : chain_dn[i]);
    assign bad_digit[i]  = ~bcd_valid(load_val_s[4*i +: 4]);

    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .step   (step[i]),
      .up     (up),
      .clr    (clr),
      .load   (load_s),
      .d      (load_val_s[4*i +: 4]),
      .q      (digit_q),
      .at_max (at_max[i]),
      .at_min (at_min[i])
    );

    assign q[4*i +: 4] = digit_q;
  end

  assign tc = en & (up ? chain_up[DIGITS] : chain_dn[DIGITS]);

  // tc already folds in en, so a stepping all-9/all-0 counter is exactly a wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap <= 1'b0;
    end else if (clr || load_s) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

`ifdef BCD_CNT_LOAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_err <= 1'b0;
    end else if (clr) begin
      load_err <= 1'b0;
    end else if (load_s) begin
      load_err <= |bad_digit;
    end
  end
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter (DIGITS=4); load tests
// run only when BCD_CNT_LOAD_EN is defined, otherwise states are reached by counting.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        en;
  logic        up;
`ifdef BCD_CNT_LOAD_EN
  logic        load;
  logic [15:0] load_val;
`endif
  logic [15:0] q;
  logic        tc;
  logic        wrap;
  logic        load_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(
    .DIGITS (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .en       (en),
    .up       (up),
`ifdef BCD_CNT_LOAD_EN
    .load     (load),
    .load_val (load_val),
`endif
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic dir);
    en = 1'b1;
    up = dir;
    repeat (n) cycle();
    en = 1'b0;
  endtask

  task automatic chk_q(input string name, input logic [15:0] exp);
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL %s: q=%h expected %h", name, q, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; en = 1'b0; up = 1'b1;
`ifdef BCD_CNT_LOAD_EN
    load = 1'b0; load_val = '0;
`endif
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk_q("reset_q", 16'h0000);
    chk_bit("reset_wrap", wrap, 1'b0);
    chk_bit("reset_load_err", load_err, 1'b0);
    run(37, 1'b1);
    chk_q("count_37", 16'h0037);
    #2 rst = 1'b1;
    #1;
    chk_q("async_rst_q", 16'h0000);
    chk_bit("async_rst_wrap", wrap, 1'b0);
    chk_bit("async_rst_load_err", load_err, 1'b0);
    rst = 1'b0;
    cycle();
    chk_q("after_rst_hold", 16'h0000);
  endtask

  task automatic test_up_carry();
`ifdef BCD_CNT_LOAD_EN
    load = 1'b1; load_val = 16'h0099;
    cycle();
    load = 1'b0;
`else
    run(99, 1'b1);
`endif
    chk_q("preset_0099", 16'h0099);
    en = 1'b1; up = 1'b1;
    #1;
    chk_bit("carry_tc_0099", tc, 1'b0);
    cycle();
    chk_q("carry_0100", 16'h0100);
    chk_bit("carry_tc_0100", tc, 1'b0);
    cycle();
    chk_q("carry_0101", 16'h0101);
    chk_bit("carry_wrap", wrap, 1'b0);
    en = 1'b0;
  endtask

  task automatic test_up_wrap();
`ifdef BCD_CNT_LOAD_EN
    load = 1'b1; load_val = 16'h9999;
    cycle();
    load = 1'b0;
`else
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    run(1, 1'b0);
`endif
    chk_q("preset_9999", 16'h9999);
    en = 1'b1; up = 1'b1;
    #1;
    chk_bit("up_wrap_tc", tc, 1'b1);
    cycle();
    en = 1'b0;
    chk_q("up_wrap_q", 16'h0000);
    chk_bit("up_wrap_pulse", wrap, 1'b1);
    cycle();
    chk_bit("up_wrap_pulse_end", wrap, 1'b0);
    chk_q("up_wrap_hold", 16'h0000);
  endtask

  task automatic test_down();
    en = 1'b1; up = 1'b0;
    #1;
    chk_bit("down_wrap_tc", tc, 1'b1);
    up = 1'b1;
    #1;
    chk_bit("down_wrap_tc_dir", tc, 1'b0);
    up = 1'b0;
    cycle();
    en = 1'b0;
    chk_q("down_wrap_q", 16'h9999);
    chk_bit("down_wrap_pulse", wrap, 1'b1);
    cycle();
    chk_bit("down_wrap_pulse_end", wrap, 1'b0);
`ifdef BCD_CNT_LOAD_EN
    load = 1'b1; load_val = 16'h1000;
    cycle();
    load = 1'b0;
`else
    run(8999, 1'b0);
`endif
    chk_q("preset_1000", 16'h1000);
    run(1, 1'b0);
    chk_q("down_borrow_0999", 16'h0999);
    chk_bit("down_borrow_wrap", wrap, 1'b0);
  endtask

  task automatic test_priority();
    logic [15:0] held;
`ifdef BCD_CNT_LOAD_EN
    clr = 1'b1; load = 1'b1; load_val = 16'h1234; en = 1'b1; up = 1'b1;
    cycle();
    chk_q("clr_over_load_en", 16'h0000);
    clr = 1'b0;
    cycle();
    load = 1'b0; en = 1'b0;
    chk_q("load_over_en", 16'h1234);
    held = 16'h1234;
`else
    clr = 1'b1; en = 1'b1; up = 1'b1;
    cycle();
    clr = 1'b0; en = 1'b0;
    chk_q("clr_over_en", 16'h0000);
    run(5, 1'b1);
    chk_q("count_0005", 16'h0005);
    held = 16'h0005;
`endif
    repeat (5) cycle();
    chk_q("hold_5_cycles", held);
    chk_bit("hold_wrap", wrap, 1'b0);
  endtask

  task automatic test_back_to_back();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    run(5, 1'b1);
    en = 1'b1;
    up = 1'b1; cycle();
    chk_q("b2b_up", 16'h0006);
    up = 1'b0; cycle();
    chk_q("b2b_down", 16'h0005);
    up = 1'b1; cycle();
    chk_q("b2b_up_again", 16'h0006);
    en = 1'b0;
  endtask

  task automatic test_invalid_load();
`ifdef BCD_CNT_LOAD_EN
    load = 1'b1; load_val = 16'h12A4;
    cycle();
    load = 1'b0;
    chk_q("bad_load_q", 16'h1204);
    chk_bit("bad_load_err", load_err, 1'b1);
    run(1, 1'b1);
    chk_q("bad_load_count", 16'h1205);
    chk_bit("load_err_sticky", load_err, 1'b1);
    load = 1'b1; load_val = 16'h0005;
    cycle();
    load = 1'b0;
    chk_q("good_load_q", 16'h0005);
    chk_bit("good_load_err", load_err, 1'b0);
    load = 1'b1; load_val = 16'hF000;
    cycle();
    load = 1'b0;
    chk_q("bad_top_digit", 16'h0000);
    chk_bit("bad_top_err", load_err, 1'b1);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk_bit("clr_load_err", load_err, 1'b0);
`else
    run(3, 1'b0);
    chk_bit("no_load_err_tied", load_err, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_up_carry();
    test_up_wrap();
    test_down();
    test_priority();
    test_back_to_back();
    test_invalid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit synchronous BCD up/down counter with enable, synchronous clear, optional parallel load, and cascade/terminal-count outputs. It is the general counting element for display, timer and event-count datapaths. It replaces single-digit mod-10 counters with one block of N decimal digits that counts in either direction and wraps cleanly.

## Interface
- DIGITS, 4, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear to zero
- en  in  1  count enable; one step per clk when high
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous parallel load (present only with BCD_CNT_LOAD_EN)
- load_val  in  4*DIGITS  load value, digit i at bits [4i+3:4i] (present only with BCD_CNT_LOAD_EN)
- q  out  4*DIGITS  count, digit 0 least significant
- tc  out  1  terminal count, combinational: en & (up ? all digits 9 : all digits 0)
- wrap  out  1  registered one-cycle pulse, high in the cycle after a wrap-around step
- load_err  out  1  registered; high in the cycle after a load that contained any digit > 9

## Operation
- Priority per rising edge: rst > clr > load > en > hold.
- rst asserted at any time forces q = 0, wrap = 0, load_err = 0 immediately. Deassertion is not synchronised inside the block.
- clr: q <= 0, wrap <= 0, load_err <= 0.
- load: each digit takes load_val digit; any digit > 9 is written as 0 and load_err <= 1, otherwise load_err <= 0; wrap <= 0.
- Counting with en=1, up=1: digit 0 increments. Digit i increments only when all lower digits = 9. A digit at 9 that steps goes to 0.
- Counting with en=1, up=0: digit 0 decrements. Digit i decrements only when all lower digits = 0. A digit at 0 that steps goes to 9.
- Wrap-around: up from all-9 gives all-0; down from all-0 gives all-9. In both cases wrap <= 1 for exactly one cycle.
- en=0 with no clr/load: q holds, wrap <= 0, load_err holds.
- load_err clears on the next load with valid digits, on clr, or on rst. It is not cleared by counting.
- q digits are always 0..9 under all legal operations. Digits never hold A–F.
- up may change every cycle; each step uses the up value sampled at that edge.

## Timing
- Latency: q reflects a count/clr/load one clk after the sampling edge.
- tc is combinational from q, en and up, valid in the same cycle. It is intended for cascading a second counter's en.
- wrap and load_err are registered, asserted the cycle after the causing edge, and cleared the following cycle as defined above.
- No multicycle paths; the digit carry chain is combinational across all DIGITS within one clock.

## Configuration
- BCD_CNT_LOAD_EN defined: the load and load_val ports exist and load behaves as specified; load_err is functional.
- Not defined: the load and load_val ports are absent, load_err is tied to 0, and priority reduces to rst > clr > en > hold.

## Structure
- Shared package bcd_pkg holds:
  - typedef bcd_digit_t (4-bit)
  - constants BCD_MAX = 4'd9 and BCD_MIN = 4'd0
  - function bcd_valid(digit) for the > 9 check
- Sub-module bcd_digit is instantiated DIGITS times via generate:
  - inputs: step, up, clr, load, d
  - outputs: q, at_max, at_min
- The top level builds the ripple-enable chain (step_i = en & AND of lower at_max/at_min) and the wrap/load_err registers.

## Test plan
- Reset and async behaviour: DIGITS=4, count to 0x0037, assert rst mid-cycle → q = 0x0000 immediately, wrap = 0, load_err = 0.
- Up count with cascaded carry: load 0x0099, en=1, up=1 for 2 cycles → q = 0x0100 then 0x0101; tc = 0 throughout.
- Up wrap: load 0x9999, en=1, up=1 → tc = 1 before the edge, q = 0x0000 after, wrap = 1 for exactly one cycle.
- Down count and down wrap: load 0x1000, up=0, step once → q = 0x0999. From 0x0000, step once → q = 0x9999 with wrap pulse.
- Priority and hold: assert clr+load+en together → q = 0. Assert load+en → q = load_val. With en=0 for 5 cycles → q unchanged.
- Invalid load (macro defined): load_val = 0x12A4 → q = 0x1204, load_err = 1. Next load 0x0005 → load_err = 0. Rebuild without the macro → ports absent, load_err constant 0.
